hf14a_tag_tx: RTL

- ISO14443-A tag-side transmitter for HF simulation (TAGSIM_MOD major path).
- Takes response bytes from the ARM-side byte interface and frames them as SOF, data bits LSB-first, and odd parity per byte, followed by EOF.
- Manchester-encodes each bit onto an fc/16 (847.5 kHz) subcarrier and drives a load-modulation enable toward the antenna driver logic.
- It is the counterpart of the reader-side subcarrier modulation detector.

---
 rtl/hf14a_pkg.sv | 45 ++++
 rtl/hf14a_manchester_slot.sv | 53 +++++
 rtl/hf14a_tag_tx.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/hf14a_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : hf14a_pkg
//  Description : Shared types and constants for the ISO14443-A HF path:
//                transmitter states, Manchester symbol types, timing
//                defaults and the major/minor mode encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package hf14a_pkg;

    // Timing defaults, in 13.56 MHz carrier clocks
    localparam int BIT_CLKS_DEF  = 128;   // one bit slot (106 kbit/s)
    localparam int SUBC_CLKS_DEF = 16;    // fc/16 subcarrier period
    localparam int EOF_SLOTS_DEF = 1;     // idle slots closing a frame

    // HF ISO14443-A minor mode encodings
    localparam logic [2:0] SNIFFER       = 3'd0;
    localparam logic [2:0] TAGSIM_LISTEN = 3'd1;
    localparam logic [2:0] TAGSIM_MOD    = 3'd2;
    localparam logic [2:0] READER_LISTEN = 3'd3;
    localparam logic [2:0] READER_MOD    = 3'd4;

    // Tag transmitter frame states
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        SOF  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        EOF  = 3'd4
    } tx_state_t;

    // Symbol carried by one bit slot
    typedef enum logic [1:0] {
        SYM_NONE = 2'd0,    // unmodulated slot
        SYM_ZERO = 2'd1,    // modulated in second half
        SYM_ONE  = 2'd2     // modulated in first half
    } sym_t;

    // Odd parity bit for one byte: total count of ones including parity is odd
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hf14a_manchester_slot.sv
`default_nettype none
// ============================================================================
//  Module      : hf14a_manchester_slot
//  Description : Manchester symbol shaper. Given the symbol and slot clock
//                that apply to the next carrier clock, registers the
//                subcarrier-gated load-modulation level so it is presented
//                exactly during that slot clock. SUBC_CLKS and BIT_CLKS are
//                powers of two with SUBC_CLKS <= BIT_CLKS.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf14a_manchester_slot
    import hf14a_pkg::*;
#(
    parameter int BIT_CLKS  = BIT_CLKS_DEF,
    parameter int SUBC_CLKS = SUBC_CLKS_DEF
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  sym,      // symbol for the coming clock
    input  logic [$clog2(BIT_CLKS)-1:0] k,        // slot clock for the coming clock
    output logic                        mod_out
);

    localparam int KW = $clog2(BIT_CLKS);
    localparam int SW = $clog2(SUBC_CLKS);

    logic first_half;
    logic subc_high;
    logic mod_d;

    // Pick the modulated half from the symbol and gate it with the subcarrier
    always_comb begin
        first_half = (k < KW'(BIT_CLKS / 2));
        subc_high  = (k[SW-1:0] < SW'(SUBC_CLKS / 2));
        mod_d      = 1'b0;
        case (sym)
            SYM_ONE:  mod_d = first_half && subc_high;
            SYM_ZERO: mod_d = !first_half && subc_high;
            default:  mod_d = 1'b0;
        endcase
    end

    // Output register: no combinational path reaches the antenna driver
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mod_out <= 1'b0;
        end else begin
            mod_out <= mod_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/hf14a_tag_tx.sv
`default_nettype none
// ============================================================================
//  Module      : hf14a_tag_tx
//  Description : ISO14443-A tag-side transmitter. Frames response bytes as
//                SOF, eight data bits LSB first and a parity bit per byte,
//                then EOF_SLOTS idle slots, and Manchester-encodes every slot
//                onto the fc/16 subcarrier. All state changes on the falling
//                edge of the 13.56 MHz carrier clock.
//                Build option: TX_PAR_OVERRIDE_EN - parity slot carries the
//                tx_par value latched with each byte instead of odd parity.
//  Revision    : 1.0 - initial release
// ============================================================================
module hf14a_tag_tx
    import hf14a_pkg::*;
#(
    parameter int BIT_CLKS  = BIT_CLKS_DEF,
    parameter int SUBC_CLKS = SUBC_CLKS_DEF,
    parameter int EOF_SLOTS = EOF_SLOTS_DEF
) (
    input  logic       ck_1356meg,
    input  logic       rst_n,
    input  logic       tx_en,
    input  logic       tx_valid,
    input  logic [7:0] tx_data,
    input  logic       tx_last,
    input  logic       tx_par,
    output logic       tx_ready,
    output logic       mod_out,
    output logic       busy,
    output logic       frame_done,
    output logic       tx_underrun
);

    localparam int KW = $clog2(BIT_CLKS);
    localparam int EW = (EOF_SLOTS > 1) ? $clog2(EOF_SLOTS) : 1;

    tx_state_t     state;
    tx_state_t     state_next;
    logic [KW-1:0] k;
    logic [KW-1:0] k_next;
    logic          k_last;
    logic [2:0]    bit_idx;
    logic [2:0]    bit_next;
    logic [EW-1:0] eof_cnt;
    logic [EW-1:0] eof_next;
    logic [7:0]    data_q;
    logic          last_q;
    logic [7:0]    data_next;
    logic          par_bit;
    logic          accept_point;
    sym_t          sym_next;

    assign k_next = k + KW'(1);
    assign k_last = (k == KW'(BIT_CLKS - 1));

    // Bytes are taken only on the last clock of an idle slot or of a parity
    // slot that still has more bytes to follow, so frames stay on the bit grid
    assign accept_point = k_last && ((state == IDLE) || ((state == PAR) && !last_q));
    assign tx_ready     = tx_en && tx_valid && accept_point;
    assign busy         = (state != IDLE);

`ifdef TX_PAR_OVERRIDE_EN
    logic par_q;

    // Externally supplied parity travels with its byte
    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            par_q <= 1'b0;
        end else if (tx_ready) begin
            par_q <= tx_par;
        end
    end

    assign par_bit = par_q;
`else
    logic unused_tx_par;
    assign unused_tx_par = tx_par;
    assign par_bit       = odd_parity(data_q);
`endif

    // Slot counter, frame state, bit/EOF counters and the byte latch
    always_ff @(negedge ck_1356meg or negedge rst_n) begin
        if (!rst_n) begin
            k       <= '0;
            state   <= IDLE;
            bit_idx <= 3'd0;
            eof_cnt <= '0;
            data_q  <= 8'd0;
            last_q  <= 1'b0;
        end else begin
            k       <= k_next;
            state   <= state_next;
            bit_idx <= bit_next;
            eof_cnt <= eof_next;
            if (tx_ready) begin
                data_q <= tx_data;
                last_q <= tx_last;
            end
        end
    end

    // Next-state logic; transitions happen only at the end of a slot
    always_comb begin
        state_next  = state;
        bit_next    = bit_idx;
        eof_next    = eof_cnt;
        frame_done  = 1'b0;
        tx_underrun = 1'b0;
        if (!tx_en) begin
            // Abort: drop the frame silently, the slot grid keeps running
            state_next = IDLE;
            bit_next   = 3'd0;
            eof_next   = '0;
        end else if (k_last) begin
            case (state)
                IDLE: begin
                    if (tx_ready) begin
                        state_next = SOF;
                    end
                end
                SOF: begin
                    state_next = DATA;
                    bit_next   = 3'd0;
                end
                DATA: begin
                    if (bit_idx == 3'd7) begin
                        state_next = PAR;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                    end
                end
                PAR: begin
                    bit_next = 3'd0;
                    eof_next = '0;
                    if (last_q) begin
                        state_next = EOF;
                    end else if (tx_ready) begin
                        state_next = DATA;
                    end else begin
                        tx_underrun = 1'b1;
                        state_next  = EOF;
                    end
                end
                EOF: begin
                    if (eof_cnt == EW'(EOF_SLOTS - 1)) begin
                        frame_done = 1'b1;
                        state_next = IDLE;
                    end else begin
                        eof_next = eof_cnt + EW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    // Symbol for the coming clock, so the shaper can register its output
    always_comb begin
        data_next = tx_ready ? tx_data : data_q;
        sym_next  = SYM_NONE;
        case (state_next)
            SOF:     sym_next = SYM_ONE;
            DATA:    sym_next = data_next[bit_next] ? SYM_ONE : SYM_ZERO;
            PAR:     sym_next = par_bit ? SYM_ONE : SYM_ZERO;
            default: sym_next = SYM_NONE;
        endcase
    end

    hf14a_manchester_slot #(
        .BIT_CLKS  (BIT_CLKS),
        .SUBC_CLKS (SUBC_CLKS)
    ) u_slot (
        .clk     (ck_1356meg),
        .rst_n   (rst_n),
        .sym     (sym_next),
        .k       (k_next),
        .mod_out (mod_out)
    );

endmodule
`default_nettype wire
